// File: rtl/hamming_weight_seq_if.sv
// Request/result bundle for the sequential Hamming weight/distance engine.
// The requester drives start/mode/a/b; the engine returns status, binary count and BCD digits.
interface hamming_weight_seq_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 4
) ();
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic                  start;
    logic                  mode;
    logic [WIDTH-1:0]      a;
    logic [WIDTH-1:0]      b;
    logic                  busy;
    logic                  done;
    logic                  ovf;
    logic [CW-1:0]         count;
    logic [4*DIGITS-1:0]   d_disp;

    modport master (
        output start, mode, a, b,
        input  busy, done, ovf, count, d_disp
    );

    modport slave (
        input  start, mode, a, b,
        output busy, done, ovf, count, d_disp
    );
endinterface

// File: rtl/hamming_weight_seq.sv
// Sequential popcount of a (or a^b), BPC bits per cycle, followed by a bit-serial
// double-dabble conversion to packed BCD with saturation on display overflow.
module hamming_weight_seq #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned BPC    = 1,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    hamming_weight_seq_if.slave   bus
);
    localparam int unsigned CW    = $clog2(WIDTH + 1);
    localparam int unsigned NSTEP = WIDTH / BPC;
    localparam int unsigned IDXW  = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam int unsigned CNTW  = $clog2(CW);
    localparam int unsigned DW    = 4 * DIGITS;

    // Decimal digits needed for the largest possible count (WIDTH).
    function automatic int unsigned dec_digits(input int unsigned n);
        int unsigned d;
        d = 1;
        for (int unsigned v = n; v >= 10; v = v / 10) begin
            d = d + 1;
        end
        return d;
    endfunction

    function automatic longint unsigned max_shown(input int unsigned dg);
        longint unsigned p;
        p = 1;
        for (int unsigned i = 0; i < dg; i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

    localparam int unsigned     BD    = dec_digits(WIDTH);
    localparam int unsigned     BW    = 4 * BD;
    // With at least BD display digits the limit exceeds WIDTH, so overflow never fires.
    localparam longint unsigned LIMIT = max_shown((DIGITS < BD) ? DIGITS : BD);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COUNT   = 2'd1,
        S_CONVERT = 2'd2,
        S_FINISH  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  v_q,     v_d;
    logic [CW-1:0]     acc_q,   acc_d;
    logic [IDXW-1:0]   idx_q,   idx_d;
    logic [CW-1:0]     bin_q,   bin_d;
    logic [BW-1:0]     bcd_q,   bcd_d;
    logic [CNTW-1:0]   cnt_q,   cnt_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
    logic              ovf_q,   ovf_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DW-1:0]     disp_q,  disp_d;

    logic [CW-1:0]     pc;
    logic [BW-1:0]     adj;
    logic [3:0]        nib;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            v_q     <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            count_q <= '0;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
            disp_q  <= disp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        count_d = count_q;
        disp_d  = disp_q;
        nib     = 4'd0;

        // The low BPC bits of v are always the next group; v shifts down each step.
        pc = '0;
        for (int unsigned i = 0; i < BPC; i++) begin
            pc = pc + CW'(v_q[i]);
        end

        // Add-3 correction applied to every BCD nibble ahead of each shift.
        adj = '0;
        for (int unsigned j = 0; j < BD; j++) begin
            nib = bcd_q[j*4 +: 4];
            adj[j*4 +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    v_d     = bus.mode ? (bus.a ^ bus.b) : bus.a;
                    acc_d   = '0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                v_d   = v_q >> BPC;
                acc_d = acc_q + pc;
                idx_d = idx_q + IDXW'(1);
                if (idx_q == IDXW'(NSTEP - 1)) begin
                    bin_d   = acc_q + pc;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CONVERT;
                end
            end
            S_CONVERT: begin
                bcd_d = {adj[BW-2:0], bin_q[CW-1]};
                bin_d = {bin_q[CW-2:0], 1'b0};
                cnt_d = cnt_q + CNTW'(1);
                if (cnt_q == CNTW'(CW - 1)) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                count_d = acc_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (64'(acc_q) > LIMIT) begin
                    ovf_d  = 1'b1;
                    disp_d = {DIGITS{4'h9}};
                end else begin
                    ovf_d  = 1'b0;
                    disp_d = DW'(bcd_q);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.ovf    = ovf_q;
    assign bus.count  = count_q;
    assign bus.d_disp = disp_q;
endmodule

// File: tb/tb_hamming_weight_seq.sv
// Randomized and directed checks of hamming_weight_seq in three configurations
// (BPC=1/DIGITS=4, BPC=4/DIGITS=4, BPC=1/DIGITS=1) against an arithmetic reference.
module tb_hamming_weight_seq;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    hamming_weight_seq_if #(.WIDTH(16), .DIGITS(4)) if0 ();
    hamming_weight_seq_if #(.WIDTH(16), .DIGITS(4)) if1 ();
    hamming_weight_seq_if #(.WIDTH(16), .DIGITS(1)) if2 ();

    hamming_weight_seq #(.WIDTH(16), .BPC(1), .DIGITS(4)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    hamming_weight_seq #(.WIDTH(16), .BPC(4), .DIGITS(4)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    hamming_weight_seq #(.WIDTH(16), .BPC(1), .DIGITS(1)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: popcount, then decimal digits by division, saturated to the display size.
    function automatic int model_count(input logic m, input logic [15:0] av, input logic [15:0] bv);
        logic [15:0] v;
        v = m ? (av ^ bv) : av;
        return $countones(v);
    endfunction

    function automatic logic [15:0] model_disp(input int u, input int n);
        logic [15:0] r;
        int          p;
        r = '0;
        if (u == 2) begin
            r = (n > 9) ? 16'h9 : 16'(n);
        end else begin
            p = 1;
            for (int i = 0; i < 4; i++) begin
                r[i*4 +: 4] = 4'((n / p) % 10);
                p = p * 10;
            end
        end
        return r;
    endfunction

    function automatic logic model_ovf(input int u, input int n);
        return (u == 2) ? (n > 9) : (n > 9999);
    endfunction

    function automatic int model_lat(input int u);
        return (u == 1) ? 10 : 22;
    endfunction

    task automatic drive(input int u, input logic st, input logic m, input logic [15:0] av, input logic [15:0] bv);
        case (u)
            0: begin if0.start = st; if0.mode = m; if0.a = av; if0.b = bv; end
            1: begin if1.start = st; if1.mode = m; if1.a = av; if1.b = bv; end
            default: begin if2.start = st; if2.mode = m; if2.a = av; if2.b = bv; end
        endcase
    endtask

    function automatic logic get_done(input int u);
        return (u == 0) ? if0.done : (u == 1) ? if1.done : if2.done;
    endfunction
    function automatic logic get_busy(input int u);
        return (u == 0) ? if0.busy : (u == 1) ? if1.busy : if2.busy;
    endfunction
    function automatic logic get_ovf(input int u);
        return (u == 0) ? if0.ovf : (u == 1) ? if1.ovf : if2.ovf;
    endfunction
    function automatic int get_count(input int u);
        return (u == 0) ? int'(if0.count) : (u == 1) ? int'(if1.count) : int'(if2.count);
    endfunction
    function automatic logic [15:0] get_disp(input int u);
        return (u == 0) ? if0.d_disp : (u == 1) ? if1.d_disp : 16'(if2.d_disp);
    endfunction

    // Start pulse accepted at edge k; returns at k+#1 with start low again.
    task automatic launch(input int u, input logic m, input logic [15:0] av, input logic [15:0] bv);
        @(negedge clk);
        drive(u, 1'b1, m, av, bv);
        @(posedge clk);
        #1;
        drive(u, 1'b0, m, av, bv);
    endtask

    // Edges after the accepting edge until done is seen; -1 if the budget runs out.
    task automatic wait_done(input int u, input int budget, output int lat, output logic busy1);
        lat   = -1;
        busy1 = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) busy1 = get_busy(u);
            if (get_done(u)) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_op(input string tag, input int u, input logic m, input logic [15:0] av, input logic [15:0] bv);
        int   n;
        int   lat;
        logic busy1;
        n = model_count(m, av, bv);
        launch(u, m, av, bv);
        wait_done(u, 60, lat, busy1);
        n_checks += 5;
        if (lat !== model_lat(u)) begin
            n_errors++; $display("FAIL %s latency u=%0d got=%0d exp=%0d", tag, u, lat, model_lat(u));
        end
        if (busy1 !== 1'b1) begin
            n_errors++; $display("FAIL %s busy_after_start u=%0d got=%b exp=1", tag, u, busy1);
        end
        if (get_count(u) !== n) begin
            n_errors++; $display("FAIL %s count u=%0d a=%h b=%h m=%b got=%0d exp=%0d", tag, u, av, bv, m, get_count(u), n);
        end
        if (get_disp(u) !== model_disp(u, n)) begin
            n_errors++; $display("FAIL %s d_disp u=%0d got=%h exp=%h", tag, u, get_disp(u), model_disp(u, n));
        end
        if (get_ovf(u) !== model_ovf(u, n)) begin
            n_errors++; $display("FAIL %s ovf u=%0d got=%b exp=%b", tag, u, get_ovf(u), model_ovf(u, n));
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int u = 0; u < 3; u++) begin
            n_checks++;
            if ({get_busy(u), get_done(u), get_ovf(u)} !== 3'b000 || get_count(u) !== 0 || get_disp(u) !== 16'h0) begin
                n_errors++;
                $display("FAIL reset_state u=%0d busy=%b done=%b ovf=%b count=%0d disp=%h exp all 0",
                         u, get_busy(u), get_done(u), get_ovf(u), get_count(u), get_disp(u));
            end
        end
    endtask

    task automatic test_weight();
        run_op("t1_all_ones", 0, 1'b0, 16'hFFFF, 16'h0000);
        @(posedge clk);
        #1;
        n_checks++;
        if (get_done(0) !== 1'b0 || get_busy(0) !== 1'b0) begin
            n_errors++; $display("FAIL done_pulse_width done=%b busy=%b exp 0 0", get_done(0), get_busy(0));
        end
        run_op("t1_zero", 0, 1'b0, 16'h0000, 16'hFFFF);
    endtask

    task automatic test_distance();
        run_op("t2_alt", 0, 1'b1, 16'hAAAA, 16'h5555);
        run_op("t2_equal", 0, 1'b1, 16'h1234, 16'h1234);
    endtask

    task automatic test_random();
        for (int i = 0; i < 36; i++) begin
            logic [15:0] av;
            logic [15:0] bv;
            av = 16'($urandom);
            bv = 16'($urandom);
            if (i % 6 == 5) av = av | 16'hFF7F;
            run_op("random", i % 3, 1'($urandom), av, bv);
        end
    endtask

    task automatic test_busy_ignore();
        int          first_lat;
        int          ndone;
        logic [15:0] disp_at_done;
        first_lat    = -1;
        ndone        = 0;
        disp_at_done = '0;
        launch(0, 1'b0, 16'h0001, 16'h0000);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            drive(0, (c == 6) || (c == 12), 1'(c), 16'(c * 16'h1111), 16'hF0F0);
            @(posedge clk);
            #1;
            if (get_done(0)) begin
                ndone++;
                if (first_lat < 0) begin
                    first_lat    = c;
                    disp_at_done = get_disp(0);
                end
            end
        end
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        n_checks += 3;
        if (ndone !== 1) begin
            n_errors++; $display("FAIL t3_single_done got=%0d exp=1", ndone);
        end
        if (first_lat !== 22) begin
            n_errors++; $display("FAIL t3_latency got=%0d exp=22", first_lat);
        end
        if (disp_at_done !== 16'h0001) begin
            n_errors++; $display("FAIL t3_d_disp got=%h exp=0001", disp_at_done);
        end
    endtask

    task automatic test_mid_reset();
        int ndone;
        ndone = 0;
        launch(0, 1'b0, 16'h00FF, 16'h0000);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (get_busy(0) !== 1'b0 || get_done(0) !== 1'b0 || get_count(0) !== 0 || get_disp(0) !== 16'h0 || get_ovf(0) !== 1'b0) begin
            n_errors++;
            $display("FAIL t4_abort busy=%b done=%b count=%0d disp=%h ovf=%b exp all 0",
                     get_busy(0), get_done(0), get_count(0), get_disp(0), get_ovf(0));
        end
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (get_done(0)) ndone++;
        end
        n_checks++;
        if (ndone !== 0) begin
            n_errors++; $display("FAIL t4_no_done got=%0d exp=0", ndone);
        end
        run_op("t4_fresh", 0, 1'b0, 16'h00FF, 16'h0000);
    endtask

    task automatic test_back_to_back();
        int   lat;
        logic busy1;
        run_op("t5_first", 1, 1'b0, 16'h0F0F, 16'h0000);
        drive(1, 1'b1, 1'b0, 16'h00F3, 16'h0000);
        @(posedge clk);
        #1;
        drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        wait_done(1, 40, lat, busy1);
        n_checks += 3;
        if (lat !== 10) begin
            n_errors++; $display("FAIL t5_b2b_latency got=%0d exp=10", lat);
        end
        if (get_disp(1) !== 16'h0006) begin
            n_errors++; $display("FAIL t5_b2b_d_disp got=%h exp=0006", get_disp(1));
        end
        if (busy1 !== 1'b1) begin
            n_errors++; $display("FAIL t5_b2b_busy got=%b exp=1", busy1);
        end
    endtask

    task automatic test_saturate();
        run_op("t6_sat", 2, 1'b0, 16'hFFFF, 16'h0000);
        run_op("t6_seven", 2, 1'b0, 16'h0007, 16'h0000);
        run_op("t6_ten", 2, 1'b1, 16'h03FF, 16'h0000);
        run_op("t6_nine", 2, 1'b1, 16'h01FF, 16'h0000);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(2, 1'b0, 1'b0, 16'h0, 16'h0);
        test_reset();
        test_weight();
        test_distance();
        test_busy_ignore();
        test_mid_reset();
        test_back_to_back();
        test_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
